// File: rtl/core_bus_bridge_pkg.sv
// Shared types and helpers for the 6502 core bus bridge: FSM state encoding,
// the data returned on an aborted external access, and the RAM region decode.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAM  = 2'd1,
        EXT  = 2'd2,
        RDY  = 2'd3
    } state_t;

    localparam logic [7:0] ERR_DATA = 8'hFF;

    // The RAM occupies the bottom 2**ram_aw bytes; everything above is external.
    function automatic logic is_ram(input logic [15:0] addr, input int unsigned ram_aw);
        return (addr >> ram_aw) == 16'd0;
    endfunction

endpackage

// File: rtl/core_bus_bridge_if.sv
// Bus bundle between the 6502 core, the on-chip RAM, the external req/ack port
// and the bridge; the bridge uses the master view, the environment the slave view.
interface core_bus_bridge_if #(
    parameter int RAM_AW = 14
);
    logic [15:0]       core_address;
    logic [7:0]        core_out;
    logic              core_we;
    logic              core_hold;
    logic [7:0]        core_in;

    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [15:0]       ext_addr;
    logic [7:0]        ext_wdata;
    logic [7:0]        ext_rdata;
    logic              ext_ack;

    modport master (
        input  core_address, core_out, core_we, ram_rdata, ext_rdata, ext_ack,
        output core_hold, core_in, ram_addr, ram_wdata, ram_we,
               ext_req, ext_we, ext_addr, ext_wdata
    );

    modport slave (
        output core_address, core_out, core_we, ram_rdata, ext_rdata, ext_ack,
        input  core_hold, core_in, ram_addr, ram_wdata, ram_we,
               ext_req, ext_we, ext_addr, ext_wdata
    );

endinterface

// File: rtl/core_bus_bridge.sv
// Paces the 6502 core's single-cycle bus onto a 1-cycle-latency RAM or a
// variable-latency req/ack port, releasing core_hold for one cycle per access.
module core_bus_bridge
    import bridge_pkg::*;
#(
    parameter int RAM_AW  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    core_bus_bridge_if.master bus,
    output logic              bus_error
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg,     state_next;
    logic [15:0]       addr_reg,      addr_next;
    logic              we_reg,        we_next;
    logic [7:0]        wdata_reg,     wdata_next;
    logic [7:0]        cnt_reg,       cnt_next;
    logic [7:0]        rdata_reg,     rdata_next;
    logic              src_ram_reg,   src_ram_next;
    logic              ext_req_reg,   ext_req_next;
    logic [RAM_AW-1:0] ram_addr_reg,  ram_addr_next;
    logic [7:0]        ram_wdata_reg, ram_wdata_next;
    logic              bus_error_reg, bus_error_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
            src_ram_reg   <= 1'b0;
            ext_req_reg   <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            src_ram_reg   <= src_ram_next;
            ext_req_reg   <= ext_req_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            bus_error_reg <= bus_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        src_ram_next   = src_ram_reg;
        ext_req_next   = ext_req_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        bus_error_next = bus_error_reg;

        case (state_reg)
            IDLE: begin
                if (run) begin
                    addr_next  = bus.core_address;
                    we_next    = bus.core_we;
                    wdata_next = bus.core_out;
                    if (is_ram(bus.core_address, RAM_AW)) begin
                        state_next     = RAM;
                        ram_addr_next  = bus.core_address[RAM_AW-1:0];
                        ram_wdata_next = bus.core_out;
                    end else begin
                        state_next   = EXT;
                        ext_req_next = 1'b1;
                        cnt_next     = '0;
                    end
                end
            end
            RAM: begin
                src_ram_next = 1'b1;
                state_next   = RDY;
            end
            EXT: begin
                // An ack arriving on the timeout edge still completes the access cleanly.
                if (bus.ext_ack) begin
                    rdata_next   = bus.ext_rdata;
                    ext_req_next = 1'b0;
                    src_ram_next = 1'b0;
                    state_next   = RDY;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next     = ERR_DATA;
                    bus_error_next = 1'b1;
                    ext_req_next   = 1'b0;
                    src_ram_next   = 1'b0;
                    state_next     = RDY;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RDY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding core_hold high during reset lets the core run its own synchronous reset.
    always_comb begin
        bus.core_hold = !reset_n || (state_reg == RDY);
        bus.core_in   = 8'h00;
        if (reset_n && state_reg == RDY) begin
            if (we_reg)
                bus.core_in = wdata_reg;
            else if (src_ram_reg)
                bus.core_in = bus.ram_rdata;
            else
                bus.core_in = rdata_reg;
        end
    end

    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign bus.ram_we    = (state_reg == RAM) && we_reg;
    assign bus.ext_req   = ext_req_reg;
    assign bus.ext_we    = we_reg;
    assign bus.ext_addr  = addr_reg;
    assign bus.ext_wdata = wdata_reg;
    assign bus_error     = bus_error_reg;

endmodule

// File: tb/tb_core_bus_bridge.sv
// Scoreboard bench for core_bus_bridge: directed core accesses push expected
// core_in/bus_error; a monitor pops and compares on every core_hold pulse.
module tb_core_bus_bridge;

    localparam int RAM_AW  = 14;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [7:0] data;
        logic       err;
        string      name;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    logic bus_error;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // Environment state shared between stimulus, responder and monitor.
    int          ack_at = 0;
    logic [7:0]  ack_data = 8'h00;
    int          ext_cycle = 0;
    int          ext_req_cycles = 0;
    int          ram_we_cycles = 0;
    int          ext_bad = 0;
    int          ram_bad = 0;
    logic        prev_hold = 1'b0;
    logic [15:0] exp_ext_addr = 16'h0;
    logic        exp_ext_we = 1'b0;
    logic [7:0]  exp_wdata = 8'h00;
    logic [RAM_AW-1:0] exp_ram_addr = '0;

    logic [7:0] mem [0:(1<<RAM_AW)-1];

    always #5 clock = ~clock;

    core_bus_bridge_if #(.RAM_AW(RAM_AW)) bus ();

    core_bus_bridge #(
        .RAM_AW (RAM_AW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .bus      (bus),
        .bus_error(bus_error)
    );

    // Synchronous RAM model: write-enable and registered read on the same edge.
    always @(posedge clock) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // External responder: acks in EXT cycle number ack_at (0 = never).
    initial begin
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = 8'h00;
        forever begin
            @(negedge clock);
            if (bus.ext_req && reset_n) begin
                ext_cycle++;
                bus.ext_ack   = (ext_cycle == ack_at);
                bus.ext_rdata = bus.ext_ack ? ack_data : 8'h00;
            end else begin
                ext_cycle     = 0;
                bus.ext_ack   = 1'b0;
                bus.ext_rdata = 8'h00;
            end
        end
    end

    // Monitor: bus-side activity counters and the scoreboard pop on core_hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.ext_req) begin
                    ext_req_cycles++;
                    if (bus.ext_addr !== exp_ext_addr || bus.ext_we !== exp_ext_we ||
                        bus.ext_wdata !== exp_wdata)
                        ext_bad++;
                end
                if (bus.ram_we) begin
                    ram_we_cycles++;
                    if (bus.ram_addr !== exp_ram_addr || bus.ram_wdata !== exp_wdata)
                        ram_bad++;
                end
                if (bus.core_hold) begin
                    chk("hold_not_back_to_back", 16'(prev_hold), 16'd0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_hold: got core_in %h expected no access", bus.core_in);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_core_in"}, 16'(bus.core_in), 16'(e.data));
                        chk({e.name, "_bus_error"}, 16'(bus_error), 16'(e.err));
                    end
                end
                prev_hold = bus.core_hold;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic access(input string name, input logic [15:0] addr, input logic we,
                          input logic [7:0] wd, input logic [7:0] exp_data, input logic exp_err,
                          input int ack_cycle, input logic [7:0] ack_d,
                          input int exp_lat, input int exp_req, input logic drop_run);
        int  n;
        bit  seen;
        @(negedge clock);
        bus.core_address = addr;
        bus.core_we      = we;
        bus.core_out     = wd;
        run              = 1'b1;
        ack_at           = ack_cycle;
        ack_data         = ack_d;
        exp_ext_addr     = addr;
        exp_ext_we       = we;
        exp_wdata        = wd;
        exp_ram_addr     = addr[RAM_AW-1:0];
        ext_req_cycles   = 0;
        ram_we_cycles    = 0;
        ext_bad          = 0;
        ram_bad          = 0;
        sb_q.push_back('{data: exp_data, err: exp_err, name: name});
        n    = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge clock);
            n++;
            if (drop_run)
                run = 1'b0;
            if (bus.core_hold)
                seen = 1;
        end
        run = 1'b0;
        chk({name, "_latency"}, 16'(n), 16'(exp_lat));
        chk({name, "_ext_req_cycles"}, 16'(ext_req_cycles), 16'(exp_req));
        chk({name, "_ram_we_cycles"}, 16'(ram_we_cycles),
            16'(((addr < 16'h4000) && we) ? 1 : 0));
        chk({name, "_bus_fields"}, 16'(ext_bad + ram_bad), 16'd0);
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_hold"},      16'(bus.core_hold), 16'd1);
        chk({name, "_core_in"},   16'(bus.core_in),   16'h00);
        chk({name, "_ext_req"},   16'(bus.ext_req),   16'd0);
        chk({name, "_ram_we"},    16'(bus.ram_we),    16'd0);
        chk({name, "_bus_error"}, 16'(bus_error),     16'd0);
        chk({name, "_ram_addr"},  16'(bus.ram_addr),  16'h0000);
        chk({name, "_ext_addr"},  16'(bus.ext_addr),  16'h0000);
    endtask

    initial begin
        int quiet;
        bus.core_address = 16'h0000;
        bus.core_out     = 8'h00;
        bus.core_we      = 1'b0;
        for (int i = 0; i < (1 << RAM_AW); i++)
            mem[i] = 8'h00;
        mem[14'h0123] = 8'h5A;

        repeat (2) @(negedge clock);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_hold", 16'(bus.core_hold), 16'd0);

        access("ram_rd_0123", 16'h0123, 1'b0, 8'h00, 8'h5A, 1'b0, 0, 8'h00, 2, 0, 1'b0);
        access("ram_wr_01ff", 16'h01FF, 1'b1, 8'h3C, 8'h3C, 1'b0, 0, 8'h00, 2, 0, 1'b0);
        access("ram_rb_01ff", 16'h01FF, 1'b0, 8'h00, 8'h3C, 1'b0, 0, 8'h00, 2, 0, 1'b0);
        access("ext_rd_fffc", 16'hFFFC, 1'b0, 8'h00, 8'h80, 1'b0, 5, 8'h80, 6, 5, 1'b0);
        access("ext_wr_8000", 16'h8000, 1'b1, 8'hA7, 8'hA7, 1'b0, 1, 8'h00, 2, 1, 1'b0);
        access("ack_on_timeout", 16'hC000, 1'b0, 8'h00, 8'h42, 1'b0, TIMEOUT, 8'h42,
               TIMEOUT + 1, TIMEOUT, 1'b0);
        access("run_drop", 16'h4000, 1'b0, 8'h00, 8'h11, 1'b0, 3, 8'h11, 4, 3, 1'b1);
        quiet = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.core_hold) quiet++;
        end
        chk("run_drop_parked", 16'(quiet), 16'd0);

        access("timeout_c000", 16'hC000, 1'b0, 8'h00, 8'hFF, 1'b1, 0, 8'h00,
               TIMEOUT + 1, TIMEOUT, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                access("sticky_ram", 16'h0123, 1'b0, 8'h00, 8'h5A, 1'b1, 0, 8'h00, 2, 0, 1'b0);
            else
                access("sticky_ext", 16'h9000, 1'b0, 8'h00, 8'(8'h20 + i), 1'b1, 2,
                       8'(8'h20 + i), 3, 2, 1'b0);
        end

        // Reset in the middle of an unacknowledged external request.
        @(negedge clock);
        bus.core_address = 16'hA000;
        bus.core_we      = 1'b0;
        ack_at           = 0;
        run              = 1'b1;
        repeat (3) @(negedge clock);
        chk("midreset_req_before", 16'(bus.ext_req), 16'd1);
        run     = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        check_reset_state("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("midreset_release_hold", 16'(bus.core_hold), 16'd0);

        access("after_reset_rb", 16'h01FF, 1'b0, 8'h00, 8'h3C, 1'b0, 0, 8'h00, 2, 0, 1'b0);
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
